branch_cond_unit: RTL and testbench
===================================

// Module: branch_cond_unit
// PURPOSE
//   Parametrised, registered successor to the CON flip-flop branch logic.
//   - Evaluates an instruction condition field against the bus value, or against an operand A latched from the bus.
//   - Produces a held branch flag (con_out) for the control unit.
//   - Adds two-operand compares, a fixed evaluation latency, a busy/valid handshake and optional statistics.
// PARAMETERS
//   DATA_W   32  bus and operand width (>=2)
//   COND_W   3   condition field width; only codes 0..7 defined, upper bits must be 0
//   CNT_W    16  statistics counter width (used only with BRANCH_STATS_EN)
// PORTS
//   clk          in   1          rising-edge clock
//   clear        in   1          synchronous, active-low reset
//   cond_in      in   COND_W     condition code from IR
//   bus_in       in   DATA_W     BusMux output
//   lda          in   1          latch bus_in into operand A register
//   evaluate     in   1          start evaluation (sample cond_in, bus_in)
//   busy         out  1          evaluation in progress
//   con_valid    out  1          one-cycle pulse: con_out just updated
//   con_out      out  1          branch-taken flag, held until next result
//   taken_cnt    out  CNT_W      [BRANCH_STATS_EN] taken evaluations, saturating
//   eval_cnt     out  CNT_W      [BRANCH_STATS_EN] total evaluations, saturating
// BEHAVIOUR
//   Reset: clear==0 at edge -> state IDLE; opA, con_out, con_valid, busy, counters = 0.
//     Reset wins over every other input; aborts any evaluation, with no con_valid pulse.
//   Conditions (B = sampled bus_in):
//     0 B==0 | 1 B!=0 | 2 B[MSB]==0 (zero counts positive) | 3 B[MSB]==1
//     4 A==B | 5 A!=B | 6 $signed(A)<$signed(B) | 7 A<B unsigned
//     Codes >7 (COND_W>3) -> result 0.
//   FSM: IDLE -> SAMPLE -> RESOLVE -> IDLE
//     IDLE:    evaluate=1 at edge T: register cond_in, bus_in and a snapshot of opA; busy=1 -> SAMPLE.
//     SAMPLE:  compute compare from registered values -> RESOLVE.
//     RESOLVE: edge T+2 writes con_out; con_valid=1 for cycle T+2..T+3; busy=0 -> IDLE.
//   Latency: evaluate edge to con_out/con_valid = 2 cycles. Throughput: one evaluation per 3 cycles.
//   busy is high in SAMPLE and RESOLVE.
//   Handshake rules:
//     - evaluate while busy is ignored; the caller must wait for !busy.
//     - evaluate in the IDLE cycle immediately after con_valid is accepted.
//   lda rules:
//     - lda at any edge (busy or not) loads opA <= bus_in.
//     - An in-flight evaluation uses the opA snapshot taken at its evaluate edge.
//     - lda and evaluate at the same edge: the evaluation uses the OLD opA; opA takes the new value.
//   Outputs: con_out changes only on a RESOLVE edge or reset. con_valid is never high for two consecutive cycles.
//   Compare arithmetic is exactly DATA_W wide; no extension beyond the signed/unsigned semantics above.
// CONFIGURATION
//   BRANCH_STATS_EN defined:
//     - At each RESOLVE edge eval_cnt += 1, and taken_cnt += 1 if the result is 1.
//     - Both counters saturate at all-ones and never wrap; both reset to 0.
//   BRANCH_STATS_EN undefined:
//     - taken_cnt and eval_cnt ports and their logic are absent.
//     - All other behaviour is identical.
// TESTING
//   1 DATA_W=32, cond=0, bus=0, evaluate -> busy 2 cycles; con_out=1 and con_valid pulse at T+2.
//   2 cond=1, bus=0x0000_0001 -> con_out=1; then cond=1, bus=0 -> con_out=0.
//     Check con_out holds between results.
//   3 cond=2, bus=0x0000_0000 -> 1; cond=3, bus=0x8000_0000 -> 1; cond=2, bus=0xFFFF_FFFF -> 0.
//   4 lda with bus=0xFFFF_FFFF, then evaluate with bus=0x0000_0001:
//     cond=6 -> 1 (-1<1); cond=7 -> 0.
//     Then lda and evaluate at the same edge -> the old opA is used.
//   5 evaluate while busy -> ignored (single con_valid).
//     clear=0 at the SAMPLE edge -> no con_valid; con_out=0, busy=0.
//   6 BRANCH_STATS_EN, CNT_W=2: 5 taken evaluations -> taken_cnt=eval_cnt=3 (saturated).
//     Reset -> both 0.

Source files
------------

// File: rtl/branch_cond_unit.sv
// Registered branch-condition evaluator with a three-state IDLE/SAMPLE/RESOLVE flow and a held con_out flag.
// Define BRANCH_STATS_EN to add saturating taken/total evaluation counters.
module branch_cond_unit #(
  parameter int DATA_W = 32,
  parameter int COND_W = 3
`ifdef BRANCH_STATS_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [COND_W-1:0] cond_in,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              lda,
  input  logic              evaluate,
  output logic              busy,
  output logic              con_valid,
  output logic              con_out
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  eval_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    RESOLVE = 2'd2
  } state_e;

  state_e            state_q;
  logic [COND_W-1:0] cond_q;
  logic [DATA_W-1:0] bus_q;
  logic [DATA_W-1:0] opa_q;
  logic [DATA_W-1:0] snap_q;
  logic              result_q;
  logic              busy_q;
  logic              valid_q;
  logic              con_q;
  logic              cmp_d;
`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0]  taken_q;
  logic [CNT_W-1:0]  eval_q;
`endif

  // Codes above 7 only exist when COND_W > 3 and always resolve to not-taken.
  always_comb begin
    cmp_d = 1'b0;
    if (32'(cond_q) <= 32'd7) begin
      case (cond_q[2:0])
        3'd0: cmp_d = (bus_q == '0);
        3'd1: cmp_d = (bus_q != '0);
        3'd2: cmp_d = ~bus_q[DATA_W-1];
        3'd3: cmp_d = bus_q[DATA_W-1];
        3'd4: cmp_d = (snap_q == bus_q);
        3'd5: cmp_d = (snap_q != bus_q);
        3'd6: cmp_d = ($signed(snap_q) < $signed(bus_q));
        3'd7: cmp_d = (snap_q < bus_q);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q  <= IDLE;
      cond_q   <= '0;
      bus_q    <= '0;
      opa_q    <= '0;
      snap_q   <= '0;
      result_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      con_q    <= 1'b0;
`ifdef BRANCH_STATS_EN
      taken_q  <= '0;
      eval_q   <= '0;
`endif
    end else begin
      // opA loads independently of the FSM; the snapshot keeps in-flight work stable.
      if (lda) opa_q <= bus_in;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (evaluate) begin
            cond_q  <= cond_in;
            bus_q   <= bus_in;
            snap_q  <= opa_q;
            busy_q  <= 1'b1;
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          result_q <= cmp_d;
          state_q  <= RESOLVE;
        end
        RESOLVE: begin
          con_q   <= result_q;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
`ifdef BRANCH_STATS_EN
          if (eval_q != '1) eval_q <= eval_q + CNT_W'(1);
          if (result_q && (taken_q != '1)) taken_q <= taken_q + CNT_W'(1);
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign con_valid = valid_q;
  assign con_out   = con_q;
`ifdef BRANCH_STATS_EN
  assign taken_cnt = taken_q;
  assign eval_cnt  = eval_q;
`endif

endmodule

// File: tb/tb_branch_cond_unit.sv
// Scoreboard bench for branch_cond_unit: directed cases plus randomized evaluations against a reference model.
// Stats counters are exercised when BRANCH_STATS_EN is defined.
module tb_branch_cond_unit;
  localparam int DATA_W = 32;
  localparam int COND_W = 3;
`ifdef BRANCH_STATS_EN
  localparam int CNT_W  = 2;
`endif

  logic              clk = 1'b0;
  logic              clear;
  logic [COND_W-1:0] cond_in;
  logic [DATA_W-1:0] bus_in;
  logic              lda;
  logic              evaluate;
  logic              busy;
  logic              con_valid;
  logic              con_out;
`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0]  taken_cnt;
  logic [CNT_W-1:0]  eval_cnt;
  int                takenModel;
  int                evalModel;
`endif

  typedef struct {
    logic res;
    int   cyc;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic        expHeld = 1'b0;
  logic        prevValid = 1'b0;
  logic [31:0] opAModel = '0;

  branch_cond_unit #(
    .DATA_W(DATA_W),
    .COND_W(COND_W)
`ifdef BRANCH_STATS_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk),
    .clear(clear),
    .cond_in(cond_in),
    .bus_in(bus_in),
    .lda(lda),
    .evaluate(evaluate),
    .busy(busy),
    .con_valid(con_valid),
    .con_out(con_out)
`ifdef BRANCH_STATS_EN
    ,
    .taken_cnt(taken_cnt),
    .eval_cnt(eval_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic refCond(input int code, input logic [31:0] a, input logic [31:0] b);
    case (code)
      0: return b == 0;
      1: return b != 0;
      2: return int'(b) >= 0;
      3: return int'(b) < 0;
      4: return a == b;
      5: return a != b;
      6: return int'(a) < int'(b);
      7: return a < b;
      default: return 1'b0;
    endcase
  endfunction

  // Monitor: every con_valid pulse must match the oldest outstanding evaluation.
  always @(negedge clk) begin
    exp_t e;
    if (con_valid === 1'b1) begin
      checkOutput("valid_single", 32'(prevValid), 32'd0);
      if (sb.size() == 0) begin
        checkOutput("unexpected_valid", 32'(con_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("con_out", 32'(con_out), 32'(e.res));
        checkOutput("latency", cyc, e.cyc);
        expHeld = e.res;
      end
    end else begin
      checkOutput("con_out_hold", 32'(con_out), 32'(expHeld));
    end
    prevValid = con_valid;
  end

  task automatic doReset(input int n);
    clear = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    expHeld  = 1'b0;
    opAModel = '0;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_valid", 32'(con_valid), 32'd0);
    checkOutput("reset_con_out", 32'(con_out), 32'd0);
`ifdef BRANCH_STATS_EN
    takenModel = 0;
    evalModel  = 0;
    checkOutput("reset_taken_cnt", 32'(taken_cnt), 32'd0);
    checkOutput("reset_eval_cnt", 32'(eval_cnt), 32'd0);
`endif
    repeat (n - 1) @(posedge clk);
    #1 clear = 1'b1;
  endtask

  task automatic loadA(input logic [31:0] v);
    bus_in = v;
    lda    = 1'b1;
    @(posedge clk); #1;
    lda      = 1'b0;
    opAModel = v;
  endtask

  // One full evaluation; returns at T+2+#1 so the next call can issue at edge T+3.
  task automatic applyStimulus(input int code, input logic [31:0] b, input bit withLda, input bit ldaBusy);
    logic res;
    cond_in  = COND_W'(code);
    bus_in   = b;
    evaluate = 1'b1;
    lda      = withLda;
    res = refCond(code, opAModel, b);
    if (withLda) opAModel = b;
    @(posedge clk); #1;
    evaluate = 1'b0;
    lda      = 1'b0;
    sb.push_back('{res: res, cyc: cyc + 2});
`ifdef BRANCH_STATS_EN
    if (evalModel < 3) evalModel++;
    if (res && takenModel < 3) takenModel++;
`endif
    checkOutput("busy_T0", 32'(busy), 32'd1);
    cond_in = COND_W'($urandom);
    bus_in  = $urandom;
    if (ldaBusy) begin
      lda      = 1'b1;
      opAModel = bus_in;
    end
    @(posedge clk); #1;
    lda = 1'b0;
    checkOutput("busy_T1", 32'(busy), 32'd1);
    @(posedge clk); #1;
    checkOutput("busy_T2", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] b;
    int          code;
    cond_in  = '0;
    bus_in   = '0;
    lda      = 1'b0;
    evaluate = 1'b0;
    clear    = 1'b0;
    doReset(2);

    applyStimulus(0, 32'h0, 0, 0);
    applyStimulus(1, 32'h1, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(1, 32'h0, 0, 0);
    applyStimulus(2, 32'h0, 0, 0);
    applyStimulus(3, 32'h8000_0000, 0, 0);
    applyStimulus(2, 32'hFFFF_FFFF, 0, 0);

    loadA(32'hFFFF_FFFF);
    applyStimulus(6, 32'h1, 0, 0);
    applyStimulus(7, 32'h1, 0, 0);
    applyStimulus(4, 32'h5, 1, 0);
    applyStimulus(4, 32'h5, 0, 0);

    // Hold evaluate across the busy cycles; only the first edge may start work.
    cond_in  = '0;
    bus_in   = '0;
    evaluate = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{res: refCond(0, opAModel, 32'h0), cyc: cyc + 2});
    @(posedge clk); #1;
    @(posedge clk); #1;
    evaluate = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset at the SAMPLE edge aborts the evaluation silently.
    cond_in  = 3'd1;
    bus_in   = 32'h0;
    evaluate = 1'b1;
    @(posedge clk); #1;
    evaluate = 1'b0;
    checkOutput("abort_busy_pre", 32'(busy), 32'd1);
    doReset(1);
    repeat (5) @(posedge clk);
    #1;

    for (int i = 0; i < 80; i++) begin
      code = int'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0: b = 32'h0;
        1: b = opAModel;
        2: b = 32'h8000_0000 | 32'($urandom);
        3: b = opAModel + 32'($urandom_range(0, 2)) - 32'd1;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) loadA($urandom);
      applyStimulus(code, b, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

`ifdef BRANCH_STATS_EN
    doReset(2);
    applyStimulus(1, 32'h0, 0, 0);
    checkOutput("taken_cnt_1", 32'(taken_cnt), 32'(takenModel));
    checkOutput("eval_cnt_1", 32'(eval_cnt), 32'(evalModel));
    for (int i = 0; i < 5; i++) applyStimulus(0, 32'h0, 0, 0);
    checkOutput("taken_cnt_sat", 32'(taken_cnt), 32'd3);
    checkOutput("eval_cnt_sat", 32'(eval_cnt), 32'd3);
    doReset(2);
`endif

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("scoreboard_drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
